// File: rtl/imem_loader_if.sv
// Handshake and instruction-memory write bus between the byte-stream loader and its surroundings.
// master = loader side (drives in_ready, the write port and status); slave = stream source / memory / core side.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              reload;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_reset;
    logic              load_done;
    logic              load_error;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        input  in_data, in_valid, reload,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output core_reset, load_done, load_error, words_loaded
    );

    modport slave (
        output in_data, in_valid, reload,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  core_reset, load_done, load_error, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory, one word per 4 bytes,
// holding the RV32I core in reset until the image is complete.
//
//   state  | meaning
//   LEN0   | waiting for length low byte
//   LEN1   | waiting for length high byte, range-check N
//   DATA   | assembling words and issuing writes
//   DONE   | image written, core released
//   ERR    | N larger than memory depth, core held in reset
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.master bus
);
    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] C_DEPTH = 17'd1 << ADDR_W;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_in_ready;
    logic [7:0]        r_len_lo;
    logic [15:0]       r_len;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_asm;
    logic [ADDR_W-1:0] r_word_idx;
    logic [ADDR_W:0]   r_words_loaded;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_core_reset;
    logic              r_load_done;
    logic              r_load_error;

    logic              w_xfer;
    logic [15:0]       w_len;
    logic              w_word_done;
    logic              w_last;
    logic              w_reload_entry;
    logic [ADDR_W:0]   w_count_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_LEN0;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_xfer         = bus.in_valid & r_in_ready;
        w_len          = {bus.in_data, r_len_lo};
        w_word_done    = (r_state == S_DATA) && w_xfer && (r_byte_cnt == 2'd3);
        w_count_inc    = r_words_loaded + {{ADDR_W{1'b0}}, 1'b1};
        // 17-bit compare so that N = 2^ADDR_W is reachable
        w_last         = ({{(16 - ADDR_W){1'b0}}, w_count_inc} == {1'b0, r_len});
        w_reload_entry = ((r_state == S_DONE) || (r_state == S_ERR)) && bus.reload;
        w_state_next   = r_state;
        case (r_state)
            S_LEN0: begin
                if (w_xfer) w_state_next = S_LEN1;
            end
            S_LEN1: begin
                if (w_xfer) begin
                    if (w_len == 16'd0) begin
                        w_state_next = S_DONE;
                    end else if ({1'b0, w_len} > C_DEPTH) begin
                        w_state_next = S_ERR;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_word_done && w_last) w_state_next = S_DONE;
            end
            S_DONE, S_ERR: begin
                if (bus.reload) w_state_next = S_LEN0;
            end
            default: w_state_next = S_LEN0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_ready     <= 1'b0;
            r_len_lo       <= 8'd0;
            r_len          <= 16'd0;
            r_byte_cnt     <= 2'd0;
            r_asm          <= 24'd0;
            r_word_idx     <= '0;
            r_words_loaded <= '0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= 32'd0;
            r_core_reset   <= 1'b1;
            r_load_done    <= 1'b0;
            r_load_error   <= 1'b0;
        end else begin
            r_in_ready <= (w_state_next == S_LEN0) || (w_state_next == S_LEN1) ||
                          (w_state_next == S_DATA);
            r_mem_we   <= w_word_done;

            if (w_xfer && (r_state == S_LEN0)) begin
                r_len_lo <= bus.in_data;
            end
            if (w_xfer && (r_state == S_LEN1)) begin
                r_len      <= w_len;
                r_byte_cnt <= 2'd0;
                r_word_idx <= '0;
                if (w_state_next == S_ERR) r_load_error <= 1'b1;
            end
            if (w_xfer && (r_state == S_DATA)) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                r_asm      <= {bus.in_data, r_asm[23:8]};
            end
            if (w_word_done) begin
                r_mem_addr     <= r_word_idx;
                r_mem_wdata    <= {bus.in_data, r_asm};
                r_word_idx     <= r_word_idx + {{(ADDR_W - 1){1'b0}}, 1'b1};
                r_words_loaded <= w_count_inc;
            end

            // release happens one edge after DONE is entered, i.e. after the last write pulse
            if (w_reload_entry) begin
                r_core_reset   <= 1'b1;
                r_load_done    <= 1'b0;
                r_load_error   <= 1'b0;
                r_words_loaded <= '0;
            end else if (r_state == S_DONE) begin
                r_core_reset <= 1'b0;
                r_load_done  <= 1'b1;
            end
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.core_reset   = r_core_reset;
    assign bus.load_done    = r_load_done;
    assign bus.load_error   = r_load_error;
    assign bus.words_loaded = r_words_loaded;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: images built from random words, a write-capturing memory model,
// a table of length cases plus hand-written sequences for reset and reload corners.
module tb_imem_loader;
    logic clk;
    logic rst;

    imem_loader_if #(.ADDR_W(8)) bus ();
    imem_loader #(.ADDR_W(8)) dut (.clk(clk), .reset(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int n;
        bit exp_err;
        int exp_words;
        int max_gap;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] img   [0:255];
    logic [31:0] imem  [0:255];
    int          wr_addr [0:4095];
    int          we_total = 0;

    // model of the instruction memory: capture every write pulse
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            imem[bus.mem_addr] = bus.mem_wdata;
            wr_addr[we_total]  = int'(bus.mem_addr);
            we_total           = we_total + 1;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, time %0t, required finish before 800000", $time);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int t;
        repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("in_ready_timeout", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic run_image(input int n, input bit exp_err, input int exp_words,
                             input int max_gap, input int reload_at, input int abort_at);
        int          base;
        int          nw;
        logic [31:0] w;
        bus.reload = 1'b1;
        @(negedge clk);
        bus.reload = 1'b0;
        chk("reload_core_reset", bus.core_reset, 1);
        chk("reload_load_done", bus.load_done, 0);
        chk("reload_load_error", bus.load_error, 0);
        chk("reload_words", bus.words_loaded, 0);
        chk("reload_in_ready", bus.in_ready, 1);
        base = we_total;
        send_byte(8'(n), max_gap);
        chk("len0_no_we", bus.mem_we, 0);
        send_byte(8'(n >> 8), max_gap);
        chk("len1_no_we", bus.mem_we, 0);
        if (exp_err) begin
            chk("err_flag", bus.load_error, 1);
            chk("err_in_ready", bus.in_ready, 0);
            chk("err_core_reset", bus.core_reset, 1);
            repeat (4) @(negedge clk);
            chk("err_flag_hold", bus.load_error, 1);
            chk("err_core_reset_hold", bus.core_reset, 1);
            chk("err_in_ready_hold", bus.in_ready, 0);
            chk("err_done", bus.load_done, 0);
            chk("err_words", bus.words_loaded, 32'(exp_words));
            chk("err_no_writes", 32'(we_total - base), 0);
            return;
        end
        nw = n;
        for (int k = 0; k < nw; k++) begin
            w = img[k];
            for (int j = 0; j < 4; j++) begin
                if (k * 4 + j == abort_at) return;
                if (k * 4 + j == reload_at) bus.reload = 1'b1;
                send_byte(w[8*j +: 8], max_gap);
                bus.reload = 1'b0;
                chk("we_latency", bus.mem_we, (j == 3) ? 32'd1 : 32'd0);
                if (j == 3) begin
                    chk("we_addr", bus.mem_addr, 32'(k));
                    chk("we_data", bus.mem_wdata, w);
                    chk("words_running", bus.words_loaded, 32'(k + 1));
                    chk("core_held", bus.core_reset, 1);
                end
            end
        end
        chk("release_not_early", bus.core_reset, 1);
        chk("done_not_early", bus.load_done, 0);
        @(negedge clk);
        chk("release_core_reset", bus.core_reset, 0);
        chk("done_flag", bus.load_done, 1);
        chk("done_in_ready", bus.in_ready, 0);
        chk("done_no_error", bus.load_error, 0);
        chk("done_words", bus.words_loaded, 32'(exp_words));
        chk("write_count", 32'(we_total - base), 32'(exp_words));
        for (int k = 0; k < nw; k++) begin
            chk("mem_content", imem[k], img[k]);
            chk("write_order", 32'(wr_addr[base + k]), 32'(k));
        end
    endtask

    vec_t tbl [8];
    int   base_r;

    initial begin
        tbl[0] = '{n: 1,     exp_err: 1'b0, exp_words: 1,   max_gap: 3};
        tbl[1] = '{n: 3,     exp_err: 1'b0, exp_words: 3,   max_gap: 0};
        tbl[2] = '{n: 0,     exp_err: 1'b0, exp_words: 0,   max_gap: 2};
        tbl[3] = '{n: 257,   exp_err: 1'b1, exp_words: 0,   max_gap: 0};
        tbl[4] = '{n: 256,   exp_err: 1'b0, exp_words: 256, max_gap: 0};
        tbl[5] = '{n: 65535, exp_err: 1'b1, exp_words: 0,   max_gap: 1};
        tbl[6] = '{n: 5,     exp_err: 1'b0, exp_words: 5,   max_gap: 5};
        tbl[7] = '{n: 512,   exp_err: 1'b1, exp_words: 0,   max_gap: 0};

        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.reload   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_core_reset", bus.core_reset, 1);
        chk("rst_load_done", bus.load_done, 0);
        chk("rst_load_error", bus.load_error, 0);
        chk("rst_words", bus.words_loaded, 0);
        rst = 1'b1;
        #1;
        chk("in_ready_before_edge", bus.in_ready, 0);
        @(negedge clk);
        chk("in_ready_after_edge", bus.in_ready, 1);

        // multiply program, back-to-back and then with random gaps
        img[0] = 32'h3e800093; img[1] = 32'h00700113; img[2] = 32'h00000193; img[3] = 32'h001181b3;
        img[4] = 32'hfff10113; img[5] = 32'hfe011ce3; img[6] = 32'h0031a023; img[7] = 32'hff5ff36f;
        run_image(8, 1'b0, 8, 0, -1, -1);
        run_image(8, 1'b0, 8, 5, -1, -1);

        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < 256; k++) img[k] = $urandom;
            run_image(tbl[v].n, tbl[v].exp_err, tbl[v].exp_words, tbl[v].max_gap, -1, -1);
        end

        // reset after 2 words and 2 bytes of word 2
        for (int k = 0; k < 3; k++) img[k] = $urandom;
        base_r = we_total;
        run_image(3, 1'b0, 3, 1, -1, 10);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", bus.in_ready, 0);
        chk("midrst_mem_we", bus.mem_we, 0);
        chk("midrst_mem_addr", bus.mem_addr, 0);
        chk("midrst_mem_wdata", bus.mem_wdata, 0);
        chk("midrst_core_reset", bus.core_reset, 1);
        chk("midrst_load_done", bus.load_done, 0);
        chk("midrst_words", bus.words_loaded, 0);
        chk("midrst_writes_before", 32'(we_total - base_r), 2);
        chk("midrst_mem0_kept", imem[0], img[0]);
        chk("midrst_mem1_kept", imem[1], img[1]);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) img[k] = $urandom;
        run_image(3, 1'b0, 3, 1, -1, -1);

        // reload from DONE with a one-word image; reload held mid-data must be ignored
        img[0] = 32'h00000013;
        run_image(1, 1'b0, 1, 0, 1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream instruction-memory loader for the RV32I core. It accepts a length-prefixed little-endian byte stream over a valid/ready handshake, typically from a UART receiver or debug link. It writes each assembled 32-bit word into the instruction memory write port and holds the core in reset until the image is complete. This is the in-silicon writer for the instruction memory the core fetches from, replacing backdoor memory initialisation.

## Interface
- `ADDR_W`, 8: instruction memory word-address width; depth = 2^ADDR_W words.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_data` input 8: stream byte.
- `in_valid` input 1: `in_data` valid.
- `in_ready` output 1: loader accepts a byte this cycle.
- `reload` input 1: single-cycle pulse; restarts loading from DONE or ERR.
- `mem_we` output 1: instruction memory write enable, one-cycle pulse per word.
- `mem_addr` output ADDR_W: word index of the write.
- `mem_wdata` output 32: word being written.
- `core_reset` output 1: active-high reset to the RV32I core.
- `load_done` output 1: image fully written and core released.
- `load_error` output 1: length field exceeded memory depth.
- `words_loaded` output ADDR_W+1: words written so far.

## Operation
- Transfer: a byte moves on any rising edge where `in_valid & in_ready` is high. `in_data` is ignored otherwise.
- Stream format: byte 0 = N[7:0], byte 1 = N[15:8], then N words of 4 bytes each, least-significant byte first. Word k is written to `mem_addr` = k.
- States:
  - LEN0: `in_ready`=1; on transfer, latch N[7:0] and go to LEN1.
  - LEN1: `in_ready`=1; on transfer, latch N[15:8], then:
    - N=0 → DONE.
    - N > 2^ADDR_W → ERR.
    - otherwise → DATA, with byte counter = 0 and word index = 0.
  - DATA: `in_ready`=1.
    - Each transfer shifts the byte into the assembly register and increments the 2-bit byte counter, which wraps 3→0.
    - On the 4th byte the word is complete. Next cycle: `mem_we`=1, `mem_addr`=word index, `mem_wdata`={b3,b2,b1,b0}. The word index and `words_loaded` increment on that same edge.
    - If that word is word N-1, the state moves to DONE on the same edge that raises `mem_we`.
  - DONE: `in_ready`=0, `load_done`=1, `core_reset`=0. `reload` → LEN0.
  - ERR: `in_ready`=0, `load_error`=1, `core_reset`=1, no writes issued. `reload` → LEN0.
- `core_reset`:
  - 1 in LEN0, LEN1, DATA and ERR.
  - Deasserts on the first edge in DONE, so the core leaves reset no earlier than the cycle after the final `mem_we` pulse.
- `reload` in LEN0, LEN1 or DATA is ignored.
- On entry to LEN0 via `reload`:
  - `core_reset`=1; `load_done` and `load_error` clear.
  - `words_loaded` resets to 0.
  - Memory contents are not cleared.
- Width rules:
  - N is a 16-bit count.
  - The depth comparison is done at 17 bits, so N = 2^ADDR_W is legal and fills memory exactly.
  - Word index never exceeds 2^ADDR_W − 1.

## Timing
- Reset values while `reset`=0, asynchronous:
  - state = LEN0.
  - `in_ready`=0 while `reset` is held low; `in_ready`=1 from the first edge after release.
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `core_reset`=1.
  - `load_done`=0, `load_error`=0, `words_loaded`=0.
- Throughput: one byte per cycle. `in_ready` never drops mid-image, so back-to-back words produce a `mem_we` pulse every 4 cycles.
- Write latency: `mem_we` asserts exactly 1 cycle after the 4th byte's transfer edge.
- Release latency: `core_reset` falls 1 cycle after the last `mem_we` pulse (1 cycle after LEN1's transfer edge when N=0).
- Stalls: `in_valid` gaps at any byte position, including between words, only delay progress; partial words are held.
- Reset mid-load: asynchronous return to LEN0 with `core_reset`=1. Words already written stay in memory; the partial word is discarded.
- Outputs are registered; no combinational path from `in_valid` to `in_ready`.

## Test plan
- Reset then stream N=8 plus the 8-word multiply program (first bytes 00 08 → wait, N bytes are 08 00, then 93 00 80 3e …) → 8 `mem_we` pulses, mem[0]=0x3e800093 … mem[7]=0xff5ff36f; `core_reset` falls 1 cycle after the mem[7] write; `words_loaded`=8; `load_done`=1.
- Same image with random `in_valid` gaps (0–5 cycles) → identical writes and addresses; no `mem_we` before a 4th byte is accepted.
- N=0 (bytes 00 00) → no writes; `load_done`=1 and `core_reset`=0 one cycle after the second length byte.
- ADDR_W=8 cases:
  - N=257 (01 01) → ERR; `load_error`=1; `in_ready`=0; `core_reset` stays 1; no `mem_we`.
  - N=256 → 256 writes, last at `mem_addr`=255, `load_done`=1.
- Assert `reset`=0 after 2 words and 2 bytes of word 2 → outputs return to their reset values immediately; after release, a full 3-word reload writes mem[0..2] correctly.
- From DONE, pulse `reload` and stream a 1-word image 0x00000013 → `core_reset` rises on the `reload` edge, mem[0]=0x00000013, then `core_reset` falls again.
